// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register indices with speculative and
// committed allocation heads, so that a flush recovers speculative allocations.
module phys_reg_free_list #(
  parameter int PHYS_COUNT = 64,
  parameter int ARCH_COUNT = 32,
  parameter int IDX_W      = $clog2(PHYS_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_alloc_req,
  output logic             o_alloc_valid,
  output logic [IDX_W-1:0] o_alloc_index,
  output logic             o_set_invalid_en,
  output logic [IDX_W-1:0] o_set_invalid_index,
  input  logic             i_commit_dst,
  input  logic             i_free_en,
  input  logic [IDX_W-1:0] i_free_index,
  output logic [IDX_W:0]   o_free_count,
  output logic             o_empty
);

  localparam int             FREE_MAX = PHYS_COUNT - ARCH_COUNT;
  localparam logic [IDX_W:0] CNT_INIT = (IDX_W+1)'(FREE_MAX);

  logic [IDX_W-1:0] r_ring [PHYS_COUNT];
  logic [IDX_W-1:0] r_spec_head;
  logic [IDX_W-1:0] r_commit_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_spec_cnt;
  logic [IDX_W:0]   r_commit_cnt;

  logic             w_alloc;
  logic [IDX_W-1:0] w_commit_head_nxt;
  logic [IDX_W:0]   w_commit_cnt_nxt;
  logic [IDX_W:0]   w_spec_cnt_nxt;
  logic [IDX_W-1:0] w_spec_head_nxt;

  assign o_alloc_valid       = (r_spec_cnt != '0);
  assign o_empty             = (r_spec_cnt == '0);
  assign o_free_count        = r_spec_cnt;
  assign o_alloc_index       = r_ring[r_spec_head];
  assign o_set_invalid_index = o_alloc_index;
  assign w_alloc             = i_alloc_req & o_alloc_valid & ~i_flush;
  assign o_set_invalid_en    = w_alloc;

  // A flush restores the speculative state from the committed state as it
  // stands after this cycle's commit and release, not before.
  always_comb begin
    w_commit_head_nxt = r_commit_head + IDX_W'(i_commit_dst);
    w_commit_cnt_nxt  = r_commit_cnt - (IDX_W+1)'(i_commit_dst) + (IDX_W+1)'(i_free_en);
    if (i_flush) begin
      w_spec_head_nxt = w_commit_head_nxt;
      w_spec_cnt_nxt  = w_commit_cnt_nxt;
    end else begin
      w_spec_head_nxt = r_spec_head + IDX_W'(w_alloc);
      w_spec_cnt_nxt  = r_spec_cnt - (IDX_W+1)'(w_alloc) + (IDX_W+1)'(i_free_en);
    end
  end

  // NOTE: the ring is reset because its initial contents are the free indices
  // themselves; nonblocking assignments keep all state updates simultaneous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PHYS_COUNT; k++) begin
        r_ring[k] <= (k < FREE_MAX) ? IDX_W'(ARCH_COUNT + k) : '0;
      end
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= IDX_W'(FREE_MAX);
      r_spec_cnt    <= CNT_INIT;
      r_commit_cnt  <= CNT_INIT;
    end else begin
      if (i_free_en) begin
        r_ring[r_tail] <= i_free_index;
        r_tail         <= r_tail + 1'b1;
      end
      r_spec_head   <= w_spec_head_nxt;
      r_commit_head <= w_commit_head_nxt;
      r_spec_cnt    <= w_spec_cnt_nxt;
      r_commit_cnt  <= w_commit_cnt_nxt;
    end
  end

  a_no_overfree: assert property (@(posedge clk) disable iff (rst)
    i_free_en |-> (w_spec_cnt_nxt <= CNT_INIT))
    else $error("free list overflow on release");

  a_commit_has_inflight: assert property (@(posedge clk) disable iff (rst)
    i_commit_dst |-> (r_commit_cnt != r_spec_cnt))
    else $error("commit with no in-flight allocation");

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: allocation, drain/empty, release,
// commit/flush recovery, long balanced traffic with wrap, async reset.
module tb_phys_reg_free_list;

  localparam int PHYS_COUNT = 64;
  localparam int ARCH_COUNT = 32;
  localparam int IDX_W      = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_flush, i_alloc_req, i_commit_dst, i_free_en;
  logic [IDX_W-1:0] i_free_index;
  logic             o_alloc_valid, o_set_invalid_en, o_empty;
  logic [IDX_W-1:0] o_alloc_index, o_set_invalid_index;
  logic [IDX_W:0]   o_free_count;

  int errors = 0;
  int checks = 0;

  phys_reg_free_list #(.PHYS_COUNT(PHYS_COUNT), .ARCH_COUNT(ARCH_COUNT), .IDX_W(IDX_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_flush            (i_flush),
    .i_alloc_req        (i_alloc_req),
    .o_alloc_valid      (o_alloc_valid),
    .o_alloc_index      (o_alloc_index),
    .o_set_invalid_en   (o_set_invalid_en),
    .o_set_invalid_index(o_set_invalid_index),
    .i_commit_dst       (i_commit_dst),
    .i_free_en          (i_free_en),
    .i_free_index       (i_free_index),
    .o_free_count       (o_free_count),
    .o_empty            (o_empty)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic idle_inputs();
    i_flush = 0; i_alloc_req = 0; i_commit_dst = 0; i_free_en = 0; i_free_index = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_alloc_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %0b want 1", o_alloc_valid); end
    checks++; if (o_alloc_index !== 6'd32) begin errors++; $display("FAIL reset_index: got %0d want 32", o_alloc_index); end
    checks++; if (o_set_invalid_en !== 1'b0) begin errors++; $display("FAIL reset_setinv: got %0b want 0", o_set_invalid_en); end
    checks++; if (o_free_count !== 7'd32) begin errors++; $display("FAIL reset_count: got %0d want 32", o_free_count); end
    checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %0b want 0", o_empty); end
  endtask

  task automatic test_alloc3();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); i_alloc_req = 1; #1;
      checks++; if (o_set_invalid_index !== 6'(32 + i) || o_set_invalid_en !== 1'b1) begin
        errors++; $display("FAIL alloc3_idx%0d: got %0d en=%0b want %0d en=1", i, o_set_invalid_index, o_set_invalid_en, 32 + i);
      end
    end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (o_free_count !== 7'd29) begin errors++; $display("FAIL alloc3_count: got %0d want 29", o_free_count); end
  endtask

  task automatic test_drain_release();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); i_alloc_req = 1; #1;
      checks++; if (o_alloc_index !== 6'(32 + i)) begin errors++; $display("FAIL drain_idx%0d: got %0d want %0d", i, o_alloc_index, 32 + i); end
    end
    @(negedge clk); #1;
    checks++; if (o_empty !== 1'b1 || o_alloc_valid !== 1'b0 || o_set_invalid_en !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got empty=%0b valid=%0b en=%0b want 1 0 0", o_empty, o_alloc_valid, o_set_invalid_en);
    end
    @(negedge clk); i_free_en = 1; i_free_index = 6'd5; #1;
    checks++; if (o_empty !== 1'b1 || o_set_invalid_en !== 1'b0) begin
      errors++; $display("FAIL release_nobypass: got empty=%0b en=%0b want 1 0", o_empty, o_set_invalid_en);
    end
    @(negedge clk); i_free_en = 0; #1;
    checks++; if (o_alloc_valid !== 1'b1 || o_alloc_index !== 6'd5 || o_set_invalid_en !== 1'b1) begin
      errors++; $display("FAIL release_next: got valid=%0b idx=%0d en=%0b want 1 5 1", o_alloc_valid, o_alloc_index, o_set_invalid_en);
    end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL release_realloc: got empty=%0b want 1", o_empty); end
  endtask

  task automatic test_commit_flush();
    do_reset();
    repeat (3) begin @(negedge clk); i_alloc_req = 1; end
    @(negedge clk); i_alloc_req = 0; i_commit_dst = 1; i_free_en = 1; i_free_index = 6'd7;
    // Flush while rename is still requesting: nothing may be invalidated.
    @(negedge clk); idle_inputs(); i_flush = 1; i_alloc_req = 1; #1;
    checks++; if (o_set_invalid_en !== 1'b0) begin errors++; $display("FAIL flush_setinv: got %0b want 0", o_set_invalid_en); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (o_alloc_index !== 6'd33) begin errors++; $display("FAIL flush_index: got %0d want 33", o_alloc_index); end
    // Committed free entries: 32 - 1 committed + 1 freed = 32.
    checks++; if (o_free_count !== 7'd32) begin errors++; $display("FAIL flush_count: got %0d want 32", o_free_count); end
  endtask

  task automatic test_flush_release();
    do_reset();
    repeat (3) begin @(negedge clk); i_alloc_req = 1; end
    @(negedge clk); i_alloc_req = 0; i_commit_dst = 1;
    // Two allocations (33, 34) remain uncommitted; committed count is 31.
    @(negedge clk); idle_inputs(); i_flush = 1; i_free_en = 1; i_free_index = 6'd9;
    @(negedge clk); idle_inputs(); #1;
    checks++; if (o_free_count !== 7'd32) begin errors++; $display("FAIL flrel_count: got %0d want 32", o_free_count); end
    for (int i = 0; i < 31; i++) begin
      checks++; if (o_alloc_index !== 6'(33 + i)) begin errors++; $display("FAIL flrel_idx%0d: got %0d want %0d", i, o_alloc_index, 33 + i); end
      i_alloc_req = 1;
      @(negedge clk); idle_inputs(); #1;
    end
    checks++; if (o_alloc_index !== 6'd9 || o_free_count !== 7'd1) begin
      errors++; $display("FAIL flrel_tail: got idx=%0d cnt=%0d want 9 1", o_alloc_index, o_free_count);
    end
  endtask

  task automatic test_balanced_wrap();
    logic [IDX_W-1:0] free_q[$];
    logic [IDX_W-1:0] live_q[$];
    logic [PHYS_COUNT-1:0] live;
    logic [IDX_W-1:0] n, f, exp_n;
    do_reset();
    live = '0;
    for (int k = 0; k < ARCH_COUNT; k++) begin live_q.push_back(IDX_W'(k)); live[k] = 1'b1; end
    for (int k = ARCH_COUNT; k < PHYS_COUNT; k++) free_q.push_back(IDX_W'(k));
    for (int p = 0; p < 100; p++) begin
      @(negedge clk); idle_inputs(); i_alloc_req = 1; #1;
      checks++; if (o_free_count !== 7'd32) begin errors++; $display("FAIL bal_count%0d: got %0d want 32", p, o_free_count); end
      n = o_alloc_index;
      exp_n = free_q.pop_front();
      checks++; if (n !== exp_n || live[n] !== 1'b0 || o_set_invalid_en !== 1'b1) begin
        errors++; $display("FAIL bal_alloc%0d: got %0d live=%0b en=%0b want %0d", p, n, live[n], o_set_invalid_en, exp_n);
      end
      live[n] = 1'b1;
      live_q.push_back(n);
      @(negedge clk); idle_inputs();
      f = live_q.pop_front();
      live[f] = 1'b0;
      free_q.push_back(f);
      i_commit_dst = 1; i_free_en = 1; i_free_index = f;
    end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (o_free_count !== 7'd32) begin errors++; $display("FAIL bal_final: got %0d want 32", o_free_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (22) begin @(negedge clk); i_alloc_req = 1; end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (o_free_count !== 7'd10) begin errors++; $display("FAIL arst_pre: got %0d want 10", o_free_count); end
    #1 rst = 1'b1;
    #1;
    checks++; if (o_free_count !== 7'd32 || o_alloc_index !== 6'd32) begin
      errors++; $display("FAIL arst_now: got cnt=%0d idx=%0d want 32 32", o_free_count, o_alloc_index);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc3();
    test_drain_release();
    test_commit_flush();
    test_flush_release();
    test_balanced_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
